pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Interlock and redirect controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback). The pipeline has no forwarding, and the register bank has no write-to-read bypass. This block holds a scoreboard of in-flight destination registers and stalls fetch/decode on read-after-write hazards. It also flushes wrong-path work when execute redirects the PC, and exposes stall/flush event counters.

## Interface
- `DEPTH`, 3: in-flight slots tracked (execute, memory, writeback).
- `CNT_W`, 32: width of the event counters.
- `NOP`, 32'h00000013: instruction word injected on flush/bubble.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `d_valid` in 1: decode buffer holds a real instruction.
- `d_rs1`, `d_rs2` in 5: decode source register addresses.
- `d_use_rs1`, `d_use_rs2` in 1: the decode instruction reads that source.
- `d_rd` in 5, `d_regwrite` in 1: decode destination and write flag.
- `e_redirect` in 1: execute stage is changing the PC (taken branch, JAL, JALR).
- `pc_en` out 1: PC register may load.
- `dbuf_en` out 1: decode buffer may load.
- `dbuf_flush` out 1: decode buffer loads `NOP`.
- `ebuf_bubble` out 1: execute buffer loads `NOP` instead of the decode instruction.
- `state` out 2: action taken last cycle. RUN=0, STALL=1, REDIRECT=2.
- `stall_cycles` out `CNT_W`: saturating count of stall cycles.
- `flush_events` out `CNT_W`: saturating count of redirect cycles.

## Operation
- **Scoreboard:** `DEPTH` slots `{valid, rd}` forming a shift register E→M→W. The W slot retires each edge.
- **Source match:** `match(r)` = r≠0 and any valid slot has rd==r.
- **Hazard:** `hazard` = `d_valid` & ((`d_use_rs1` & match(`d_rs1`)) | (`d_use_rs2` & match(`d_rs2`))).
- **W slot stalls:** the W slot counts toward a hazard because the bank writes at the end of writeback.
- **Priority 1, redirect:** when `e_redirect`=1: `pc_en`=1, `dbuf_en`=1, `dbuf_flush`=1, `ebuf_bubble`=1. Hazard is ignored because the decode instruction is wrong-path.
- **Priority 2, stall:** when `hazard`=1: `pc_en`=0, `dbuf_en`=0, `dbuf_flush`=0, `ebuf_bubble`=1.
- **Otherwise, advance:** `pc_en`=1, `dbuf_en`=1, `dbuf_flush`=0, `ebuf_bubble`=0.
- **New E slot each edge:** valid when `d_valid` & `d_regwrite` & `d_rd`≠0 & ~`hazard` & ~`e_redirect`; rd=`d_rd`. Otherwise the slot is empty.
- **Redirecting instruction:** an instruction already in E, including a JAL/JALR that is itself redirecting, keeps its slot. Only younger work is killed.
- **Counters:** `stall_cycles` increments on each stall cycle and `flush_events` on each redirect cycle. Both hold at all-ones.
- **`state` register:** loads REDIRECT, STALL or RUN according to the action taken that cycle.
- **Stall/flush outputs:** combinational from inputs plus the registered scoreboard.

## Timing
- **Reset values** (while `reset` is high the outputs are forced to these, regardless of inputs):
  - scoreboard empty
  - `pc_en`=1, `dbuf_en`=1, `dbuf_flush`=0, `ebuf_bubble`=0
  - `state`=RUN, both counters 0
- **Stall latency by producer→consumer distance:**
  - 1 instruction: 3 stall cycles.
  - 2: 2 stall cycles.
  - 3: 1 stall cycle.
  - 4 or more: 0.
- **Consumer read:** the consumer reads in the cycle after the producer's writeback edge.
- **Stall release:** stalls release the same cycle the last matching slot shifts out. No extra cycle is added.
- **Redirect cost:** a redirect costs exactly 2 wrong-path slots (decode and fetch).
- **Back-to-back redirects:** `e_redirect` on consecutive cycles flushes each cycle.
- **Redirect during stall:** the redirect ends the stall that cycle.
- **Reset mid-stall:** clears the scoreboard immediately. The next cycle is RUN with `pc_en`=1.
- **x0:** never creates or matches a hazard.

## Structure
- **Shared package `cpu_pkg`:**
  - `ctrl_state_t` enum (RUN, STALL, REDIRECT)
  - `NOP_INSN` constant
  - `sb_slot_t` struct {valid, rd[4:0]}
- **Sub-module `hazard_scoreboard`:** the slot shift register plus the two `match` comparators. It takes the push entry and returns `hazard`.
- **`pipeline_controller` body:** priority logic, counters and `state`.

## Test plan
- **Reset:** assert `reset` mid-cycle with `d_valid`=1 and a matching source. Required: outputs at reset values asynchronously; counters 0; `state`=RUN.
- **Back-to-back RAW:** `addi x5` then `add x6,x5,x5` on consecutive decode cycles. Required: `pc_en`=0 and `ebuf_bubble`=1 for exactly 3 cycles; `stall_cycles`=3; the consumer advances on cycle 4.
- **x0 and distance:** producer writes x0, consumer reads x0, giving no stall. Producer to x7, consumer 3 instructions later, giving exactly 1 stall cycle.
- **Redirect beats hazard:** a hazard is pending (x5 in M) and `e_redirect`=1. Required: `dbuf_flush`=1, `ebuf_bubble`=1, `pc_en`=1, `state`=REDIRECT next cycle, `flush_events`=1, `stall_cycles` unchanged. The flushed decode writer of x9 is never inserted, so a later reader of x9 does not stall.
- **Counter saturation:** with `CNT_W`=4, hold a hazard for 20 stall cycles (repeated producers). Required: `stall_cycles` saturates at 15 and holds.
- **Reset mid-stall:** assert `reset` during the second stall cycle and release. Required: the next cycle has `pc_en`=1 and an empty scoreboard; the consumer is not stalled by the pre-reset producer.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline control slice.
// Controller state, NOP word and scoreboard slot.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard (E -> M -> W).
// Flags RAW hazards against the decode sources.
import cpu_pkg::*;

module hazard_scoreboard #(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  sb_slot_t   push,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_use_rs1,
  input  logic       d_use_rs2,
  output logic       hazard
);

  sb_slot_t [DEPTH-1:0] slots;
  logic m1;
  logic m2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots <= '0;
    end else begin
      slots[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        slots[i] <= slots[i-1];
      end
    end
  end

  // W still counts: the bank writes at the end of writeback
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m1 = m1 | (slots[i].valid &
                 (slots[i].rd == d_rs1));
      m2 = m2 | (slots[i].valid &
                 (slots[i].rd == d_rs2));
    end
    m1 = m1 & (|d_rs1);
    m2 = m2 & (|d_rs2);
  end

  assign hazard = d_valid &
                  ((d_use_rs1 & m1) |
                   (d_use_rs2 & m2));

endmodule

// File: rtl/pipeline_controller.sv
// Interlock and redirect controller for the 5-stage pipe.
// Stalls on RAW hazards, flushes on execute redirects.
import cpu_pkg::*;

module pipeline_controller #(
  parameter int          DEPTH = 3,
  parameter int          CNT_W = 32,
  parameter logic [31:0] NOP   = NOP_INSN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [4:0]       d_rd,
  input  logic             d_regwrite,
  input  logic             e_redirect,
  output logic             pc_en,
  output logic             dbuf_en,
  output logic             dbuf_flush,
  output logic             ebuf_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  logic        hazard;
  logic        redir;
  logic        stall;
  logic        unused_nop;
  sb_slot_t    push;
  ctrl_state_t act;
  ctrl_state_t state_q;

  assign unused_nop = ^NOP;

  // Wrong-path decode work never enters the scoreboard
  assign push = '{
    valid: d_valid & d_regwrite & (|d_rd) &
           ~hazard & ~e_redirect,
    rd:    d_rd
  };

  hazard_scoreboard #(
    .DEPTH(DEPTH)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .d_valid  (d_valid),
    .d_rs1    (d_rs1),
    .d_rs2    (d_rs2),
    .d_use_rs1(d_use_rs1),
    .d_use_rs2(d_use_rs2),
    .hazard   (hazard)
  );

  assign redir = ~reset & e_redirect;
  assign stall = ~reset & ~e_redirect & hazard;

  always_comb begin
    act         = RUN;
    pc_en       = 1'b1;
    dbuf_en     = 1'b1;
    dbuf_flush  = 1'b0;
    ebuf_bubble = 1'b0;
    unique case (1'b1)
      redir: begin
        act         = REDIRECT;
        dbuf_flush  = 1'b1;
        ebuf_bubble = 1'b1;
      end
      stall: begin
        act         = STALL;
        pc_en       = 1'b0;
        dbuf_en     = 1'b0;
        ebuf_bubble = 1'b1;
      end
      default: begin
        act = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_q <= act;
      if (stall && ~&stall_cycles) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (redir && ~&flush_events) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: vector table, corner
// sequences and random stimulus against a timing model.
module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_use_rs1;
  logic        d_use_rs2;
  logic [4:0]  d_rd;
  logic        d_regwrite;
  logic        e_redirect;

  logic        pc_en, dbuf_en, dbuf_flush, ebuf_bubble;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;

  logic        s_pc_en, s_dbuf_en, s_dbuf_flush, s_bub;
  logic [1:0]  s_state;
  logic [3:0]  s_stall, s_flush;

  pipeline_controller u_dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_rd(d_rd), .d_regwrite(d_regwrite),
    .e_redirect(e_redirect),
    .pc_en(pc_en), .dbuf_en(dbuf_en),
    .dbuf_flush(dbuf_flush),
    .ebuf_bubble(ebuf_bubble),
    .state(state),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  pipeline_controller #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_rd(d_rd), .d_regwrite(d_regwrite),
    .e_redirect(e_redirect),
    .pc_en(s_pc_en), .dbuf_en(s_dbuf_en),
    .dbuf_flush(s_dbuf_flush),
    .ebuf_bubble(s_bub),
    .state(s_state),
    .stall_cycles(s_stall),
    .flush_events(s_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: a producer decoded in cycle t is visible to
  // readers in cycles t+1 .. t+3 (E, M, W).
  typedef struct {
    logic [4:0] rd;
    int         t;
  } prod_t;

  prod_t      inflight[$];
  int         cyc;
  int         m_stall;
  int         m_flush;
  logic [1:0] m_state;

  function automatic bit busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].rd == r &&
          cyc - inflight[i].t <= 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return d_valid &&
           ((d_use_rs1 && busy(d_rs1)) ||
            (d_use_rs2 && busy(d_rs2)));
  endfunction

  function automatic logic [31:0] sat4(input int n);
    return (n > 15) ? 32'd15 : n;
  endfunction

  task automatic model_reset();
    inflight.delete();
    m_stall = 0;
    m_flush = 0;
    m_state = 2'd0;
  endtask

  task automatic model_edge();
    bit hz;
    hz = m_hazard();
    if (e_redirect) begin
      m_flush++;
      m_state = 2'd2;
    end else if (hz) begin
      m_stall++;
      m_state = 2'd1;
    end else begin
      m_state = 2'd0;
      if (d_valid && d_regwrite && d_rd != 0)
        inflight.push_back('{rd: d_rd, t: cyc});
    end
    cyc++;
    while (inflight.size() > 0 &&
           cyc - inflight[0].t > 3)
      void'(inflight.pop_front());
  endtask

  task automatic model_check();
    logic e_pc, e_fl, e_bub;
    if (reset) begin
      e_pc = 1; e_fl = 0; e_bub = 0;
    end else if (e_redirect) begin
      e_pc = 1; e_fl = 1; e_bub = 1;
    end else if (m_hazard()) begin
      e_pc = 0; e_fl = 0; e_bub = 1;
    end else begin
      e_pc = 1; e_fl = 0; e_bub = 0;
    end
    chk("m_pc_en", pc_en, e_pc);
    chk("m_dbuf_en", dbuf_en, e_pc);
    chk("m_dbuf_flush", dbuf_flush, e_fl);
    chk("m_ebuf_bubble", ebuf_bubble, e_bub);
    chk("m_state", state, m_state);
    chk("m_stall_cycles", stall_cycles, m_stall);
    chk("m_flush_events", flush_events, m_flush);
    chk("m_sat_stall", s_stall, sat4(m_stall));
    chk("m_sat_flush", s_flush, sat4(m_flush));
  endtask

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       rdr;
    logic       pc;
    logic       fl;
    logic       bub;
    logic [1:0] st;
  } vec_t;

  function automatic vec_t mk(
    input logic v,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2,
    input logic [4:0] rd, input logic rw,
    input logic rdr, input logic pc,
    input logic fl, input logic bub,
    input logic [1:0] st);
    return '{v, rs1, rs2, u1, u2, rd, rw, rdr,
             pc, fl, bub, st};
  endfunction

  task automatic drive(input vec_t x);
    d_valid    = x.v;
    d_rs1      = x.rs1;
    d_rs2      = x.rs2;
    d_use_rs1  = x.u1;
    d_use_rs2  = x.u2;
    d_rd       = x.rd;
    d_regwrite = x.rw;
    e_redirect = x.rdr;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tv[25];
  vec_t rv;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    model_reset();

    // Table: RAW b2b, x0, distance 3, redirect cases
    tv[0]  = mk(1, 0, 0, 1, 0, 5, 1, 0, 1, 0, 0, 0);
    tv[1]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 0);
    tv[2]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    tv[3]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    tv[4]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 0, 1);
    tv[5]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tv[6]  = mk(1, 0, 0, 1, 1, 8, 1, 0, 1, 0, 0, 0);
    tv[7]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
    tv[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[10] = mk(1, 7, 0, 1, 0, 10, 1, 0, 0, 0, 1, 0);
    tv[11] = mk(1, 7, 0, 1, 0, 10, 1, 0, 1, 0, 0, 1);
    tv[12] = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[14] = mk(1, 5, 0, 1, 0, 9, 1, 1, 1, 1, 1, 0);
    tv[15] = mk(1, 9, 0, 1, 0, 11, 1, 0, 1, 0, 0, 2);
    tv[16] = mk(1, 11, 0, 1, 0, 12, 1, 1, 1, 1, 1, 0);
    tv[17] = mk(1, 11, 0, 1, 0, 12, 1, 1, 1, 1, 1, 2);
    tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    tv[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[20] = mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
    tv[21] = mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1, 0);
    tv[22] = mk(1, 3, 0, 1, 0, 4, 1, 1, 1, 1, 1, 1);
    tv[23] = mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1, 2);
    tv[24] = mk(1, 3, 0, 1, 0, 4, 1, 0, 1, 0, 0, 1);

    // Reset with a live decode and redirect asserted
    reset = 1'b1;
    drive(mk(1, 5, 5, 1, 1, 5, 1, 1,
             0, 0, 0, 0));
    #3;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_dbuf_en", dbuf_en, 1);
    chk("rst_dbuf_flush", dbuf_flush, 0);
    chk("rst_ebuf_bubble", ebuf_bubble, 0);
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flush", flush_events, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 25; i++) begin
      drive(tv[i]);
      @(negedge clk);
      model_check();
      chk($sformatf("tv%0d_pc_en", i), pc_en, tv[i].pc);
      chk($sformatf("tv%0d_flush", i),
          dbuf_flush, tv[i].fl);
      chk($sformatf("tv%0d_bubble", i),
          ebuf_bubble, tv[i].bub);
      chk($sformatf("tv%0d_state", i), state, tv[i].st);
      if (i == 5)
        chk("b2b_stall_cnt", stall_cycles, 3);
      if (i == 15) begin
        chk("redir_flush_cnt", flush_events, 1);
        chk("redir_stall_cnt", stall_cycles, 4);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    chk("tbl_stall_cnt", stall_cycles, 6);
    chk("tbl_flush_cnt", flush_events, 4);

    // Reset asserted in the second stall cycle
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
    cycle();
    drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0));
    cycle();
    @(negedge clk);
    model_check();
    chk("mid_stall_bubble", ebuf_bubble, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc_en", pc_en, 1);
    chk("mid_rst_bubble", ebuf_bubble, 0);
    chk("mid_rst_stall", stall_cycles, 0);
    chk("mid_rst_state", state, 0);
    e_redirect = 1'b1;
    #1;
    chk("mid_rst_flush_forced", dbuf_flush, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    e_redirect = 1'b0;
    model_reset();
    @(negedge clk);
    model_check();
    chk("post_rst_pc_en", pc_en, 1);
    chk("post_rst_bubble", ebuf_bubble, 0);
    @(posedge clk);
    model_edge();
    #1;

    // Chain of x5 producers keeps the pipe stalled
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
    cycle();
    drive(mk(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0));
    for (int g = 0; g < 7; g++) begin
      repeat (4) cycle();
    end
    chk("sat_stall_4b", s_stall, 15);
    chk("sat_stall_32b", stall_cycles, 21);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rv.v   = ($urandom_range(0, 3) != 0);
      rv.rs1 = 5'($urandom_range(0, 7));
      rv.rs2 = 5'($urandom_range(0, 7));
      rv.u1  = 1'($urandom_range(0, 1));
      rv.u2  = 1'($urandom_range(0, 1));
      rv.rd  = 5'($urandom_range(0, 7));
      rv.rw  = ($urandom_range(0, 3) != 0);
      rv.rdr = ($urandom_range(0, 7) == 0);
      rv.pc  = 1'b0;
      rv.fl  = 1'b0;
      rv.bub = 1'b0;
      rv.st  = 2'd0;
      drive(rv);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

endmodule
